// File: rtl/a2b_tx_packetizer.sv
// a2b_tx_packetizer
//   Alice-side A2B packet builder. On an accepted start it writes one 32-bit
//   header word into the A_A2B FIFO, then streams the decoded number of
//   payload words from a first-word-fall-through source FIFO with no added
//   latency (src_dout goes straight to A_A2B_wr_din in the pop cycle).
//   One packet in flight; busy/done form the request/complete handshake.
//
// Optional build macro: A2B_TX_STATS_EN enables the tx_pkt_cnt/tx_word_cnt
//   statistics counters; without it both ports are tied to zero.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   pkt_start              1-cycle request, honoured only when idle
//   pkt_type/len_code/     packet descriptor, latched on the accepting edge
//   pkt_depth/parity_type
//   src_rd_en/dout/empty   FWFT payload source
//   A_A2B_wr_*/full        A_A2B FIFO write side (wr_din is 0 when not writing)
//   busy, done             handshake: busy while a packet is active, done 1 cycle
//   tx_pkt_cnt/word_cnt    statistics (see macro above)

`ifndef A2B_CORRECT_PARITY
`define A2B_CORRECT_PARITY 4'h1
`endif
`ifndef A2B_TARGET_HASHTAG
`define A2B_TARGET_HASHTAG 4'h2
`endif
`ifndef A2B_EV_RANDOMBIT
`define A2B_EV_RANDOMBIT   4'h3
`endif
`ifndef PACKET_LENGTH_257
`define PACKET_LENGTH_257  4'h1
`endif
`ifndef PACKET_LENGTH_514
`define PACKET_LENGTH_514  4'h2
`endif
`ifndef PACKET_LENGTH_771
`define PACKET_LENGTH_771  4'h3
`endif
`ifndef PACKET_LENGTH_1028
`define PACKET_LENGTH_1028 4'h4
`endif

module a2b_tx_packetizer #(
  parameter int DEPTH_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_start,
  input  logic [3:0]  pkt_type,
  input  logic [3:0]  pkt_len_code,
  input  logic [8:0]  pkt_depth,
  input  logic [2:0]  pkt_parity_type,
  output logic        src_rd_en,
  input  logic [31:0] src_dout,
  input  logic        src_empty,
  output logic        A_A2B_wr_clk,
  output logic        A_A2B_wr_en,
  output logic [31:0] A_A2B_wr_din,
  input  logic        A_A2B_full,
  output logic        busy,
  output logic        done,
  output logic [15:0] tx_pkt_cnt,
  output logic [31:0] tx_word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_type, r_len;
  logic [8:0]           r_depth_field;
  logic [2:0]           r_parity;
  logic [DEPTH_W-1:0]   r_remaining;

  logic [DEPTH_W-1:0]   w_decoded;
  logic [8:0]           w_depth_field;
  logic                 w_start_ok, w_wr_hdr, w_wr_pay;
  logic [31:0]          w_header;

  assign A_A2B_wr_clk = clk;

  // Length code -> payload word count; unknown codes fall back to the largest packet.
  always_comb begin
    w_decoded     = DEPTH_W'(1024);
    w_depth_field = 9'd0;
    case (pkt_len_code)
      `PACKET_LENGTH_257: begin
        w_decoded     = DEPTH_W'(pkt_depth);
        w_depth_field = pkt_depth;
      end
      `PACKET_LENGTH_514:  w_decoded = DEPTH_W'(512);
      `PACKET_LENGTH_771:  w_decoded = DEPTH_W'(768);
      `PACKET_LENGTH_1028: w_decoded = DEPTH_W'(1024);
      default:             w_decoded = DEPTH_W'(1024);
    endcase
  end

  assign w_start_ok = (r_state == S_IDLE) && pkt_start;
  assign w_wr_hdr   = (r_state == S_HEADER) && !A_A2B_full;
  // A payload beat needs data, room and outstanding count in the same cycle.
  assign w_wr_pay   = (r_state == S_PAYLOAD) && !src_empty && !A_A2B_full &&
                      (r_remaining != '0);
  assign w_header   = {r_type, r_len, r_depth_field, r_parity, 12'h000};

  // Descriptor latch and remaining-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_type        <= '0;
      r_len         <= '0;
      r_depth_field <= '0;
      r_parity      <= '0;
      r_remaining   <= '0;
    end else if (w_start_ok) begin
      r_type        <= pkt_type;
      r_len         <= pkt_len_code;
      r_depth_field <= w_depth_field;
      r_parity      <= pkt_parity_type;
      r_remaining   <= w_decoded;
    end else if (w_wr_pay) begin
      r_remaining   <= r_remaining - DEPTH_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (pkt_start) w_next = S_HEADER;
      S_HEADER:  if (w_wr_hdr) w_next = (r_remaining == '0) ? S_DONE : S_PAYLOAD;
      S_PAYLOAD: if ((r_remaining == '0) || (w_wr_pay && (r_remaining == DEPTH_W'(1))))
                   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    src_rd_en    = 1'b0;
    A_A2B_wr_en  = 1'b0;
    A_A2B_wr_din = 32'h0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_HEADER: begin
        A_A2B_wr_en  = w_wr_hdr;
        A_A2B_wr_din = w_wr_hdr ? w_header : 32'h0;
      end
      S_PAYLOAD: begin
        src_rd_en    = w_wr_pay;
        A_A2B_wr_en  = w_wr_pay;
        A_A2B_wr_din = w_wr_pay ? src_dout : 32'h0;
      end
      S_DONE:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

`ifdef A2B_TX_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      if (done)        r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      if (A_A2B_wr_en) r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign tx_pkt_cnt  = r_pkt_cnt;
  assign tx_word_cnt = r_word_cnt;
`else
  assign tx_pkt_cnt  = 16'h0;
  assign tx_word_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_a2b_tx_packetizer.sv
`timescale 1ns/1ps

`ifndef A2B_CORRECT_PARITY
`define A2B_CORRECT_PARITY 4'h1
`endif
`ifndef A2B_TARGET_HASHTAG
`define A2B_TARGET_HASHTAG 4'h2
`endif
`ifndef A2B_EV_RANDOMBIT
`define A2B_EV_RANDOMBIT   4'h3
`endif
`ifndef PACKET_LENGTH_257
`define PACKET_LENGTH_257  4'h1
`endif
`ifndef PACKET_LENGTH_514
`define PACKET_LENGTH_514  4'h2
`endif
`ifndef PACKET_LENGTH_771
`define PACKET_LENGTH_771  4'h3
`endif
`ifndef PACKET_LENGTH_1028
`define PACKET_LENGTH_1028 4'h4
`endif

module tb_a2b_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic [3:0]  pkt_type = '0, pkt_len_code = '0;
  logic [8:0]  pkt_depth = '0;
  logic [2:0]  pkt_parity_type = '0;
  logic        src_rd_en;
  logic [31:0] src_dout = '0;
  logic        src_empty = 1'b1;
  logic        A_A2B_wr_clk, A_A2B_wr_en;
  logic [31:0] A_A2B_wr_din;
  logic        A_A2B_full = 1'b0;
  logic        busy, done;
  logic [15:0] tx_pkt_cnt;
  logic [31:0] tx_word_cnt;

`ifdef A2B_TX_STATS_EN
  localparam int EXP_PKTS = 3, EXP_WORDS = 15;
`else
  localparam int EXP_PKTS = 0, EXP_WORDS = 0;
`endif

  a2b_tx_packetizer dut (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .pkt_type(pkt_type),
    .pkt_len_code(pkt_len_code), .pkt_depth(pkt_depth), .pkt_parity_type(pkt_parity_type),
    .src_rd_en(src_rd_en), .src_dout(src_dout), .src_empty(src_empty),
    .A_A2B_wr_clk(A_A2B_wr_clk), .A_A2B_wr_en(A_A2B_wr_en), .A_A2B_wr_din(A_A2B_wr_din),
    .A_A2B_full(A_A2B_full), .busy(busy), .done(done),
    .tx_pkt_cnt(tx_pkt_cnt), .tx_word_cnt(tx_word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  len;
    logic [8:0]  depth;
    logic [2:0]  par;
    int          exp_n;
    logic [31:0] exp_hdr;
  } vec_t;

  int checks = 0, errors = 0;

  // Source FIFO contents, words offered, words seen at the sink.
  logic [31:0] src_q[$], exp_q[$], cap_q[$];
  int          cap_cyc[$];
  int          cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, last_busy_cyc = 0, viol = 0;
  int          stall_pct = 0;
  bit          force_empty = 0, force_full = 0;

  // Monitor: samples mid-cycle what the next rising edge will transfer.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (pkt_start && !busy && rst_n) start_cyc = cyc;
    if (busy) last_busy_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (A_A2B_wr_en) begin
      cap_q.push_back(A_A2B_wr_din);
      cap_cyc.push_back(cyc);
    end else if (A_A2B_wr_din != 32'h0) viol++;
    if (A_A2B_wr_en && A_A2B_full) viol++;
    if (src_rd_en) begin
      if (src_empty || !A_A2B_wr_en || (A_A2B_wr_din != src_dout) || (src_q.size() == 0)) viol++;
      else void'(src_q.pop_front());
    end
  end

  // FWFT source and sink back-pressure with optional random stalls.
  initial forever begin
    @(posedge clk); #1;
    src_empty  = (src_q.size() == 0) || force_empty || (int'($urandom_range(0, 99)) < stall_pct);
    src_dout   = (src_q.size() != 0) ? src_q[0] : $urandom();
    A_A2B_full = force_full || (int'($urandom_range(0, 99)) < stall_pct);
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic pstep(); @(posedge clk); #2; endtask
  task automatic nstep(); @(negedge clk); #1; endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model written straight from the packet-format rules.
  function automatic int model_len(input logic [3:0] len, input logic [8:0] d);
    if (len == `PACKET_LENGTH_257) return int'(d);
    if (len == `PACKET_LENGTH_514) return 512;
    if (len == `PACKET_LENGTH_771) return 768;
    return 1024;
  endfunction

  function automatic logic [31:0] model_hdr(input logic [3:0] t, input logic [3:0] len,
                                            input logic [8:0] d, input logic [2:0] p);
    logic [31:0] df;
    df = (len == `PACKET_LENGTH_257) ? 32'(d) : 32'h0;
    return (32'(t) << 28) + (32'(len) << 24) + (df << 15) + (32'(p) << 12);
  endfunction

  task automatic begin_pkt(input vec_t v, input int stall, input int hold);
    logic [31:0] w;
    cap_q.delete(); cap_cyc.delete(); exp_q.delete(); src_q.delete();
    done_cnt = 0; viol = 0; stall_pct = stall;
    for (int i = 0; i < v.exp_n + 3; i++) begin
      w = $urandom();
      exp_q.push_back(w);
      src_q.push_back(w);
    end
    pstep();
    pkt_type = v.typ; pkt_len_code = v.len; pkt_depth = v.depth; pkt_parity_type = v.par;
    pkt_start = 1'b1;
    repeat (hold) pstep();
    pkt_start = 1'b0;
    // Descriptor must already be latched; scramble it.
    pkt_type = 4'($urandom()); pkt_len_code = 4'($urandom());
    pkt_depth = 9'($urandom()); pkt_parity_type = 3'($urandom());
  endtask

  task automatic end_pkt(input vec_t v, input string name);
    int n = 0, mism = 0;
    logic [31:0] hdr;
    while (done_cnt == 0 && n < 6000) begin nstep(); n++; end
    repeat (4) nstep();
    hdr = (cap_q.size() > 0) ? cap_q[0] : 32'hxxxxxxxx;
    for (int i = 1; i < cap_q.size() && i <= v.exp_n; i++)
      if (cap_q[i] !== exp_q[i-1]) mism++;
    chk({name, " done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, " word_count"}, 32'(cap_q.size()), 32'(v.exp_n + 1));
    chk({name, " header"}, hdr, v.exp_hdr);
    chk({name, " payload_mismatches"}, 32'(mism), 32'd0);
    chk({name, " src_left"}, 32'(src_q.size()), 32'd3);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " protocol_violations"}, 32'(viol), 32'd0);
    stall_pct = 0;
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{`A2B_CORRECT_PARITY, `PACKET_LENGTH_257,  9'd4,   3'b101, 4,    32'h11025000};
    vecs[1] = '{`A2B_TARGET_HASHTAG, `PACKET_LENGTH_514,  9'h1FF, 3'b011, 512,  32'h22003000};
    vecs[2] = '{`A2B_EV_RANDOMBIT,   `PACKET_LENGTH_771,  9'd7,   3'b000, 768,  32'h33000000};
    vecs[3] = '{`A2B_CORRECT_PARITY, `PACKET_LENGTH_1028, 9'd0,   3'b111, 1024, 32'h14007000};
    vecs[4] = '{4'h5,                4'hF,                9'd3,   3'b010, 1024, 32'h5F002000};
    vecs[5] = '{`A2B_TARGET_HASHTAG, `PACKET_LENGTH_257,  9'd0,   3'b100, 0,    32'h21004000};
    vecs[6] = '{`A2B_CORRECT_PARITY, `PACKET_LENGTH_257,  9'd511, 3'b001, 511,  32'h11FF9000};

    // Reset state
    repeat (3) pstep();
    nstep();
    chk("reset wr_en", 32'(A_A2B_wr_en), 32'd0);
    chk("reset wr_din", A_A2B_wr_din, 32'd0);
    chk("reset src_rd_en", 32'(src_rd_en), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset pkt_cnt", 32'(tx_pkt_cnt), 32'd0);
    chk("reset word_cnt", tx_word_cnt, 32'd0);
    pstep(); rst_n = 1'b1; pstep();

    // Exact latency, no stalls
    begin_pkt(vecs[0], 0, 1);
    end_pkt(vecs[0], "latency");
    if (cap_cyc.size() == 5)
      for (int k = 0; k < 5; k++) chk($sformatf("latency word%0d_cycle", k), 32'(cap_cyc[k] - start_cyc), 32'(k + 1));
    chk("latency done_cycle", 32'(done_cyc - start_cyc), 32'd6);
    chk("latency last_busy_cycle", 32'(last_busy_cyc - start_cyc), 32'd6);

    // Table vectors under random stalls
    for (int i = 0; i < 7; i++) begin
      begin_pkt(vecs[i], 25, 1);
      end_pkt(vecs[i], $sformatf("vec%0d", i));
    end

    // Source empty for 10 cycles in the middle of a 514 packet
    begin_pkt(vecs[1], 0, 1);
    for (int n = 0; n < 2000 && cap_q.size() < 50; n++) nstep();
    pstep();
    force_empty = 1;
    pstep();
    begin
      int w0;
      w0 = cap_q.size();
      repeat (9) pstep();
      chk("empty_gap writes", 32'(cap_q.size() - w0), 32'd0);
    end
    force_empty = 0;
    end_pkt(vecs[1], "empty_gap");

    // Sink full for 3 header cycles and 2 payload cycles
    v = '{`A2B_TARGET_HASHTAG, `PACKET_LENGTH_257, 9'd8, 3'b011, 8, 32'h21043000};
    force_full = 1;
    begin_pkt(v, 0, 1);
    repeat (2) pstep();
    force_full = 0;
    for (int n = 0; n < 2000 && cap_q.size() < 4; n++) nstep();
    pstep();
    force_full = 1;
    repeat (2) pstep();
    force_full = 0;
    end_pkt(v, "full_stall");
    if (cap_cyc.size() > 0) chk("full_stall header_cycle", 32'(cap_cyc[0] - start_cyc), 32'd4);

    // Depth 0 with start held through HEADER and DONE (extra starts ignored)
    begin_pkt(vecs[5], 0, 3);
    end_pkt(vecs[5], "depth0_restart");
    chk("depth0 done_cycle", 32'(done_cyc - start_cyc), 32'd2);

    // Reset in the middle of a 1028 packet
    v = '{`A2B_CORRECT_PARITY, `PACKET_LENGTH_1028, 9'd0, 3'b000, 1024, 32'h14000000};
    begin_pkt(v, 0, 1);
    for (int n = 0; n < 2000 && cap_q.size() < 101; n++) nstep();
    pstep();
    rst_n = 1'b0;
    pstep();
    nstep();
    chk("midreset wr_en", 32'(A_A2B_wr_en), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset src_rd_en", 32'(src_rd_en), 32'd0);
    pstep(); rst_n = 1'b1;
    begin_pkt(v, 20, 1);
    end_pkt(v, "after_reset");

    // Statistics over 3 packets of depth 4
    pstep(); rst_n = 1'b0; repeat (2) pstep(); rst_n = 1'b1; pstep();
    for (int i = 0; i < 3; i++) begin
      begin_pkt(vecs[0], 20, 1);
      end_pkt(vecs[0], $sformatf("stats%0d", i));
    end
    chk("stats tx_pkt_cnt", 32'(tx_pkt_cnt), 32'(EXP_PKTS));
    chk("stats tx_word_cnt", tx_word_cnt, 32'(EXP_WORDS));

    // Randomized packets against the reference model
    for (int r = 0; r < 6; r++) begin
      int sel;
      sel = int'($urandom_range(0, 4));
      v.typ = 4'($urandom());
      v.par = 3'($urandom());
      v.depth = 9'($urandom());
      case (sel)
        0: v.len = `PACKET_LENGTH_257;
        1: v.len = `PACKET_LENGTH_514;
        2: v.len = `PACKET_LENGTH_771;
        3: v.len = `PACKET_LENGTH_1028;
        default: v.len = 4'($urandom_range(5, 15));
      endcase
      v.exp_n = model_len(v.len, v.depth);
      v.exp_hdr = model_hdr(v.typ, v.len, v.depth, v.par);
      begin_pkt(v, 30, 1);
      end_pkt(v, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
